// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - SAP-1 six-state ring counter and microcode decoder
module control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        hlt_bar
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    localparam logic [11:0] CON_IDLE = 12'h3E3;

    state_t      state;
    state_t      state_nx;
    logic        halted;
    logic        halted_nx;
    logic        hlt_now;
    logic [11:0] con_raw;

    // Ring advances on the falling edge so control words are stable at the rising edge.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            state  <= T1;
            halted <= 1'b0;
        end else begin
            state  <= state_nx;
            halted <= halted_nx;
        end
    end

    always_comb begin
        state_nx  = T1;
        halted_nx = halted;
        hlt_now   = 1'b0;
        con_raw   = CON_IDLE;
        case (state)
            T1: begin
                con_raw  = 12'h5E3;
                state_nx = T2;
            end
            T2: begin
                con_raw  = 12'hBE3;
                state_nx = T3;
            end
            T3: begin
                con_raw  = 12'h263;
                state_nx = T4;
            end
            T4: begin
                state_nx = T5;
                if (halted) begin
                    state_nx = T4;
                end else if (opcode == OP_HLT) begin
                    hlt_now   = 1'b1;
                    halted_nx = 1'b1;
                    state_nx  = T4;
                end else if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    con_raw = 12'h1A3;
                end else if (opcode == OP_OUT) begin
                    con_raw = 12'h3F2;
                end
            end
            T5: begin
                state_nx = T6;
                if (opcode == OP_LDA) begin
                    con_raw = 12'h2C3;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    con_raw = 12'h2E1;
                end
            end
            T6: begin
                state_nx = T1;
                if (opcode == OP_ADD) begin
                    con_raw = 12'h3C7;
                end else if (opcode == OP_SUB) begin
                    con_raw = 12'h3CF;
                end
            end
            default: begin
                state_nx = T1;
            end
        endcase
    end

    // Reset masks the decoder directly so no partial word leaks while clr is low.
    assign con     = clr ? con_raw : CON_IDLE;
    assign hlt_bar = ~clr | ~(halted | hlt_now);
    assign t_state = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic        clk;
    logic        clr;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        hlt_bar;

    int pass_cnt;
    int total_cnt;

    control_sequencer dut (
        .clk     (clk),
        .clr     (clr),
        .opcode  (opcode),
        .con     (con),
        .t_state (t_state),
        .hlt_bar (hlt_bar)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Moves just past the next falling (active) edge, well before the rising edge.
    task automatic adv();
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        clr    = 1'b0;
        opcode = OP_LDA;
        repeat (3) adv();
        total_cnt++;
        if (t_state !== 6'b000001) $display("FAIL reset_t_state got=%b exp=000001", t_state);
        else pass_cnt++;
        total_cnt++;
        if (con !== 12'h3E3) $display("FAIL reset_con got=%h exp=3e3", con);
        else pass_cnt++;
        total_cnt++;
        if (hlt_bar !== 1'b1) $display("FAIL reset_hlt_bar got=%b exp=1", hlt_bar);
        else pass_cnt++;
        clr = 1'b1;
        #1;
        total_cnt++;
        if (con !== 12'h5E3) $display("FAIL release_con_t1 got=%h exp=5e3", con);
        else pass_cnt++;
        adv();
        total_cnt++;
        if (con !== 12'hBE3 || t_state !== 6'b000010)
            $display("FAIL release_t2 got con=%h t=%b exp con=be3 t=000010", con, t_state);
        else pass_cnt++;
        adv();
        total_cnt++;
        if (con !== 12'h263 || t_state !== 6'b000100)
            $display("FAIL release_t3 got con=%h t=%b exp con=263 t=000100", con, t_state);
        else pass_cnt++;
        opcode = 4'b0011;
        repeat (4) adv();
    endtask

    task automatic test_lda();
        logic [11:0] exp_con [6];
        exp_con = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3};
        for (int i = 0; i < 6; i++) begin
            if (i < 2) opcode = OP_HLT;
            if (i == 2) opcode = OP_LDA;
            total_cnt++;
            if (t_state !== (6'b000001 << i) || con !== exp_con[i] || hlt_bar !== 1'b1)
                $display("FAIL lda_T%0d got con=%h t=%b hlt_bar=%b exp con=%h t=%b hlt_bar=1",
                         i + 1, con, t_state, hlt_bar, exp_con[i], 6'b000001 << i);
            else pass_cnt++;
            adv();
        end
        total_cnt++;
        if (t_state !== 6'b000001 || con !== 12'h5E3)
            $display("FAIL lda_wrap got con=%h t=%b exp con=5e3 t=000001", con, t_state);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_con [2][6];
        exp_con[0] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7};
        exp_con[1] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3CF};
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 6; i++) begin
                if (i < 2) opcode = OP_OUT;
                if (i == 2) opcode = (n == 0) ? OP_ADD : OP_SUB;
                total_cnt++;
                if (!$onehot(t_state) || t_state !== (6'b000001 << i))
                    $display("FAIL addsub_onehot n=%0d got t=%b exp t=%b", n, t_state, 6'b000001 << i);
                else pass_cnt++;
                total_cnt++;
                if (con !== exp_con[n][i])
                    $display("FAIL addsub_con n=%0d T%0d got=%h exp=%h", n, i + 1, con, exp_con[n][i]);
                else pass_cnt++;
                adv();
            end
        end
    endtask

    task automatic test_nop();
        logic [11:0] exp_con [6];
        exp_con = '{12'h5E3, 12'hBE3, 12'h263, 12'h3E3, 12'h3E3, 12'h3E3};
        for (int i = 0; i < 7; i++) begin
            if (i == 2) opcode = 4'b0101;
            total_cnt++;
            if (t_state !== (6'b000001 << (i % 6)) || con !== exp_con[i % 6] || hlt_bar !== 1'b1)
                $display("FAIL nop_T%0d got con=%h t=%b hlt_bar=%b exp con=%h t=%b hlt_bar=1",
                         (i % 6) + 1, con, t_state, hlt_bar, exp_con[i % 6], 6'b000001 << (i % 6));
            else pass_cnt++;
            adv();
        end
        repeat (5) adv();
    endtask

    task automatic test_out_hlt();
        logic [11:0] exp_con [6];
        exp_con = '{12'h5E3, 12'hBE3, 12'h263, 12'h3F2, 12'h3E3, 12'h3E3};
        for (int i = 0; i < 6; i++) begin
            if (i == 2) opcode = OP_OUT;
            total_cnt++;
            if (t_state !== (6'b000001 << i) || con !== exp_con[i])
                $display("FAIL out_T%0d got con=%h t=%b exp con=%h t=%b",
                         i + 1, con, t_state, exp_con[i], 6'b000001 << i);
            else pass_cnt++;
            adv();
        end
        adv();
        adv();
        opcode = OP_HLT;
        adv();
        total_cnt++;
        if (t_state !== 6'b001000 || hlt_bar !== 1'b0 || con !== 12'h3E3)
            $display("FAIL hlt_T4 got con=%h t=%b hlt_bar=%b exp con=3e3 t=001000 hlt_bar=0",
                     con, t_state, hlt_bar);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            adv();
            opcode = 4'(i);
            #1;
            total_cnt++;
            if (t_state !== 6'b001000 || hlt_bar !== 1'b0 || con !== 12'h3E3)
                $display("FAIL halted_%0d got con=%h t=%b hlt_bar=%b exp con=3e3 t=001000 hlt_bar=0",
                         i, con, t_state, hlt_bar);
            else pass_cnt++;
        end
        clr = 1'b0;
        #1;
        total_cnt++;
        if (t_state !== 6'b000001 || hlt_bar !== 1'b1 || con !== 12'h3E3)
            $display("FAIL hlt_clr got con=%h t=%b hlt_bar=%b exp con=3e3 t=000001 hlt_bar=1",
                     con, t_state, hlt_bar);
        else pass_cnt++;
        clr = 1'b1;
        opcode = OP_HLT;
        #1;
        total_cnt++;
        if (con !== 12'h5E3 || hlt_bar !== 1'b1)
            $display("FAIL hlt_release got con=%h hlt_bar=%b exp con=5e3 hlt_bar=1", con, hlt_bar);
        else pass_cnt++;
        adv();
        total_cnt++;
        if (t_state !== 6'b000010)
            $display("FAIL hlt_restart got t=%b exp t=000010", t_state);
        else pass_cnt++;
        opcode = 4'b0011;
        repeat (5) adv();
    endtask

    task automatic test_async_reset();
        adv();
        adv();
        opcode = OP_ADD;
        adv();
        adv();
        total_cnt++;
        if (t_state !== 6'b010000 || con !== 12'h2E1)
            $display("FAIL arst_pre got con=%h t=%b exp con=2e1 t=010000", con, t_state);
        else pass_cnt++;
        #1;
        clr = 1'b0;
        #1;
        total_cnt++;
        if (t_state !== 6'b000001 || con !== 12'h3E3)
            $display("FAIL arst_now got con=%h t=%b exp con=3e3 t=000001", con, t_state);
        else pass_cnt++;
        adv();
        clr = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (t_state !== (6'b000001 << i) || con === 12'h3C7 ||
                con !== ((i == 0) ? 12'h5E3 : (i == 1) ? 12'hBE3 : 12'h263))
                $display("FAIL arst_after_T%0d got con=%h t=%b", i + 1, con, t_state);
            else pass_cnt++;
            adv();
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        clr       = 1'b0;
        opcode    = 4'b0000;
        test_reset();
        test_lda();
        test_back_to_back();
        test_nop();
        test_out_hlt();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) plus a microcode decoder. It sits directly downstream of the instruction register and consumes the 4-bit opcode nibble that the IR presents on its upper output. It emits the 12-bit control word that drives the program counter, MAR, RAM, IR, accumulator, ALU, B register and output register, and a halt flag that freezes the machine.

## Interface
Parameters:
- OP_LDA, 4'b0000, load accumulator from memory
- OP_ADD, 4'b0001, A <= A + mem
- OP_SUB, 4'b0010, A <= A - mem
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, halt

Ports:
- clk  input  1  system clock; state advances on the falling edge
- clr  input  1  reset, asynchronous, active-low
- opcode  input  4  instruction opcode from the IR upper nibble
- con  output  12  control word {cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar, ea, su, eu, lb_bar, lo_bar}, bit 11 = cp
- t_state  output  6  one-hot ring state; bit 0 = T1 … bit 5 = T6
- hlt_bar  output  1  low while halted

## Operation
- Ring counter: T1→T2→T3→T4→T5→T6→T1. Exactly one bit is hot. Any illegal or zero encoding recovers to T1 on the next falling edge.
- con is purely combinational from t_state and opcode. Inactive word is 0x3E3 (active-low enables high, active-high enables low).
- Fetch, for all opcodes:
  - T1 = 0x5E3 (ep, lm_bar=0)
  - T2 = 0xBE3 (cp)
  - T3 = 0x263 (ce_bar=0, li_bar=0)
- LDA: T4 = 0x1A3 (ei_bar, lm_bar); T5 = 0x2C3 (ce_bar, la_bar); T6 = 0x3E3.
- ADD: T4 = 0x1A3; T5 = 0x2E1 (ce_bar, lb_bar); T6 = 0x3C7 (la_bar, eu).
- SUB: same as ADD, except T6 = 0x3CF (su additionally high).
- OUT: T4 = 0x3F2 (ea, lo_bar); T5 and T6 = 0x3E3.
- HLT: in T4, hlt_bar goes low combinationally and con = 0x3E3. On the next falling edge t_state latches a halted condition: it stays at T4 and hlt_bar stays low until clr. No further control activity occurs.
- Undefined opcodes (0011–1101): NOP, with T4–T6 = 0x3E3. The counter continues normally.
- Opcode is decoded only during T4–T6. In T1–T3 the opcode is ignored, so a stale or changing IR value has no effect.

## Timing
- Reset: clr low immediately forces t_state = 6'b000001, con = 0x3E3, hlt_bar = 1 and clears the halted condition, independent of clk.
- After clr rises: con = 0x5E3 (T1). The first falling edge of clk moves to T2.
- Each falling edge advances one state, so one instruction takes 6 clk cycles.
- Control words are stable across each rising edge, which is where the datapath registers sample.
- The IR loads the opcode on the rising edge inside T3 (li_bar low). The opcode is therefore valid for all of T4–T6.
- Halt latency:
  - hlt_bar goes low 0 cycles after entering T4 with opcode = OP_HLT.
  - The freeze is registered at the following falling edge.
  - Once halted, a change on the opcode input has no effect.
- clr asserted mid-instruction (any T-state, halted or not): return to T1 asynchronously, with no partial control word afterward.
- clr released coincident with a falling edge: the state is T1 for that edge; advancing to T2 is permitted only on the next falling edge.

## Test plan
- Reset: clr=0 with clk running → t_state=000001, con=0x3E3, hlt_bar=1. Release → con=0x5E3, then 0xBE3 and 0x263 on successive falling edges.
- LDA: opcode=0000 → T4..T6 con = 0x1A3, 0x2C3, 0x3E3; then back to T1 with 0x5E3. One instruction spans 6 falling edges.
- ADD then SUB back-to-back: ADD T6 = 0x3C7; SUB T5 = 0x2E1 and T6 = 0x3CF. Check one-hot t_state on every cycle.
- OUT then HLT:
  - OUT T4 = 0x3F2.
  - HLT T4: hlt_bar=0, con=0x3E3.
  - Over 20 further clocks with opcode toggled, t_state stays 001000 and con stays 0x3E3.
  - clr pulse → T1, hlt_bar=1.
- Undefined opcode 0101 → T4–T6 all 0x3E3, hlt_bar=1, then the next fetch proceeds.
- Async reset mid-T5 of ADD, between clock edges → immediate t_state=000001, con=0x3E3. No 0x3C7 word appears after release.
